// File: rtl/tcdm_demux_pkg.sv
// Shared types and elaboration helpers for the TCDM request demultiplexer.
//   log2 / clog2 : constant functions for sizing select and counter fields.
//   sel_width    : slave-select field width for a given slave count.
//   req_t        : request payload bundle (address, wen, wdata, be) at default widths.
package tcdm_demux_pkg;

  // Floor log2; exact for the power-of-two slave counts this block supports.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((n >> i) != 0) r = i;
    end
    return r;
  endfunction

  // Ceiling log2, used to size counters that must hold the value n-1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned sel_width(input int unsigned n_slave);
    return (n_slave > 1) ? log2(n_slave) : 1;
  endfunction

  localparam int unsigned N_SLAVE_DEF    = 4;
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned BE_WIDTH_DEF   = DATA_WIDTH_DEF / 8;
  localparam int unsigned SEL_W          = sel_width(N_SLAVE_DEF);

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] add;
    logic                      wen;
    logic [DATA_WIDTH_DEF-1:0] wdata;
    logic [BE_WIDTH_DEF-1:0]   be;
  } req_t;

endpackage

// File: rtl/tcdm_req_demux_if.sv
// Bundle of every bus signal around the request demux: the master-side request/response
// channel and the per-slave fan-out. Names keep the demux's point of view (_i into it, _o out).
//   slave  modport : the demux itself.
//   master modport : whatever drives the master side and models the slaves.
interface tcdm_req_demux_if #(
  parameter int unsigned N_SLAVE    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
  // Master side
  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_add_i;
  logic                  data_wen_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic [BE_WIDTH-1:0]   data_be_i;
  logic                  data_gnt_o;
  logic                  data_r_valid_o;
  logic [DATA_WIDTH-1:0] data_r_rdata_o;
  // Slave side
  logic [N_SLAVE-1:0]                 data_req_o;
  logic [ADDR_WIDTH-1:0]              data_add_o;
  logic                               data_wen_o;
  logic [DATA_WIDTH-1:0]              data_wdata_o;
  logic [BE_WIDTH-1:0]                data_be_o;
  logic [N_SLAVE-1:0]                 data_gnt_i;
  logic [N_SLAVE-1:0]                 data_r_valid_i;
  logic [N_SLAVE-1:0][DATA_WIDTH-1:0] data_r_rdata_i;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
    input  data_gnt_i, data_r_valid_i, data_r_rdata_i,
    output data_gnt_o, data_r_valid_o, data_r_rdata_o,
    output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
    output data_gnt_i, data_r_valid_i, data_r_rdata_i,
    input  data_gnt_o, data_r_valid_o, data_r_rdata_o,
    input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o
  );
endinterface

// File: rtl/tcdm_outstanding_tracker.sv
// Outstanding-transaction bookkeeping for the request demux.
//   clk_i, rst_i : clock, asynchronous active-high reset.
//   tgt_i        : slave selected by the current request address.
//   push_i       : request granted this cycle.
//   pop_i        : response forwarded to the master this cycle.
//   r_valid_i    : raw per-slave response valids, used for protocol error detection.
//   allow_o      : current request may be presented to its slave.
//   cur_tgt_o    : slave owning the in-flight transactions.
//   cnt_nz_o     : at least one transaction in flight.
//   err_o        : sticky flag for responses nobody asked for.
module tcdm_outstanding_tracker
  import tcdm_demux_pkg::*;
#(
  parameter int unsigned N_SLAVE         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SelW            = sel_width(N_SLAVE)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SelW-1:0]    tgt_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [N_SLAVE-1:0] r_valid_i,
  output logic               allow_o,
  output logic [SelW-1:0]    cur_tgt_o,
  output logic               cnt_nz_o,
  output logic               err_o
);
  localparam int unsigned CntW = clog2(MAX_OUTSTANDING + 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic [SelW-1:0] cur_tgt_d, cur_tgt_q;
  logic            err_d, err_q;
  logic            spurious;

  always_comb begin
    cnt_nz_o = (cnt_q != '0);
    // No bypass at full: a pop in the same cycle does not reopen the gate.
    allow_o  = !cnt_nz_o || ((tgt_i == cur_tgt_q) && (cnt_q < CntW'(MAX_OUTSTANDING)));
    if (!cnt_nz_o) spurious = |r_valid_i;
    else           spurious = |(r_valid_i & ~(N_SLAVE'(1) << cur_tgt_q));
  end

  always_comb begin
    cnt_d     = cnt_q;
    cur_tgt_d = cur_tgt_q;
    err_d     = err_q | spurious;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push_i) cur_tgt_d = tgt_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      cur_tgt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cur_tgt_q <= cur_tgt_d;
      err_q     <= err_d;
    end
  end

  assign cur_tgt_o = cur_tgt_q;
  assign err_o     = err_q;
endmodule

// File: rtl/tcdm_req_demux.sv
// Routes one master's TCDM request channel to one of N_SLAVE slaves chosen by address bank
// bits, and returns responses in order. Requests to a different slave stall until every
// response from the current slave has come back.
//   clk_i, rst_i : clock, asynchronous active-high reset.
//   bus_io       : master request/response channel plus per-slave fan-out (slave modport).
//   err_o        : sticky flag, set by any response not matching an outstanding request.
module tcdm_req_demux
  import tcdm_demux_pkg::*;
#(
  parameter int unsigned N_SLAVE         = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned BANK_OFFSET     = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  tcdm_req_demux_if.slave          bus_io,
  output logic                     err_o
);
  localparam int unsigned SelW = sel_width(N_SLAVE);

  logic [ADDR_WIDTH-1:0] add;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] rdata;
  logic [SelW-1:0]       tgt, cur_tgt;
  logic                  allow, cnt_nz, push, pop;

  assign add   = bus_io.data_add_i;
  assign wdata = bus_io.data_wdata_i;
  assign be    = bus_io.data_be_i;
  assign tgt   = add[BANK_OFFSET +: SelW];

  // Payload is broadcast; only the per-slave request line is steered.
  assign bus_io.data_add_o   = add;
  assign bus_io.data_wen_o   = bus_io.data_wen_i;
  assign bus_io.data_wdata_o = wdata;
  assign bus_io.data_be_o    = be;

  always_comb begin
    bus_io.data_req_o      = '0;
    bus_io.data_req_o[tgt] = bus_io.data_req_i & allow;
    bus_io.data_gnt_o      = bus_io.data_req_i & allow & bus_io.data_gnt_i[tgt];
    push                   = bus_io.data_gnt_o;
  end

  // Only the owning slave's response is forwarded, and only while something is in flight.
  always_comb begin
    pop   = bus_io.data_r_valid_i[cur_tgt] & cnt_nz;
    rdata = cnt_nz ? bus_io.data_r_rdata_i[cur_tgt] : '0;
  end

  assign bus_io.data_r_valid_o = pop;
  assign bus_io.data_r_rdata_o = rdata;

  tcdm_outstanding_tracker #(
    .N_SLAVE        (N_SLAVE),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .SelW           (SelW)
  ) u_tracker (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tgt_i    (tgt),
    .push_i   (push),
    .pop_i    (pop),
    .r_valid_i(bus_io.data_r_valid_i),
    .allow_o  (allow),
    .cur_tgt_o(cur_tgt),
    .cnt_nz_o (cnt_nz),
    .err_o    (err_o)
  );
endmodule

// File: tb/tb_tcdm_req_demux.sv
// Directed bench for tcdm_req_demux (N_SLAVE=4, MAX_OUTSTANDING=4, BANK_OFFSET=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_tcdm_req_demux;
  import tcdm_demux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  tcdm_req_demux_if #(.N_SLAVE(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4)) bus ();

  tcdm_req_demux #(
    .N_SLAVE(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4),
    .BANK_OFFSET(2), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus),
    .err_o (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input req_t r, input logic [3:0] gnt);
    bus.data_req_i   = v;
    bus.data_add_i   = r.add;
    bus.data_wen_i   = r.wen;
    bus.data_wdata_i = r.wdata;
    bus.data_be_i    = r.be;
    bus.data_gnt_i   = gnt;
  endtask

  task automatic respond(input logic [3:0] vld, input int unsigned slv, input logic [31:0] d);
    bus.data_r_valid_i       = vld;
    bus.data_r_rdata_i[slv]  = d;
  endtask

  req_t rd_t0, rd_t1, rd_t2, rd_t3, wr_t3;

  initial begin
    rd_t0 = '{add: 32'h0000_0000, wen: 1'b1, wdata: 32'h0, be: 4'hF};
    rd_t1 = '{add: 32'h0000_0004, wen: 1'b1, wdata: 32'h0, be: 4'hF};
    rd_t2 = '{add: 32'h0000_0008, wen: 1'b1, wdata: 32'h0, be: 4'hF};
    rd_t3 = '{add: 32'h0000_000C, wen: 1'b1, wdata: 32'h0, be: 4'hF};
    wr_t3 = '{add: 32'h1000_003C, wen: 1'b0, wdata: 32'h1234_5678, be: 4'h6};
    drive(1'b0, rd_t0, 4'h0);
    bus.data_r_valid_i = '0;
    bus.data_r_rdata_i = '0;

    // Reset state
    #3;
    check("rst_req_o", bus.data_req_o, 4'h0);
    check("rst_rvalid_o", bus.data_r_valid_o, 0);
    check("rst_rdata_o", bus.data_r_rdata_o, 0);
    check("rst_err_o", err, 0);
    #4 rst = 1'b0;
    step();

    // Single read to slave 2
    drive(1'b1, rd_t2, 4'b0100);
    #1;
    check("t1_req_o", bus.data_req_o, 4'b0100);
    check("t1_gnt_o", bus.data_gnt_o, 1);
    check("t1_add_o", bus.data_add_o, 32'h8);
    check("t1_wen_o", bus.data_wen_o, 1);
    step();
    drive(1'b0, rd_t2, 4'h0);
    respond(4'b0100, 2, 32'hCAFE_F00D);
    #1;
    check("t1_rvalid_o", bus.data_r_valid_o, 1);
    check("t1_rdata_o", bus.data_r_rdata_o, 32'hCAFE_F00D);
    step();
    respond(4'b0000, 2, 32'hCAFE_F00D);
    #1;
    check("t1_rdata_idle", bus.data_r_rdata_o, 0);
    // Empty again: a different slave is reachable
    drive(1'b1, rd_t3, 4'h0);
    #1;
    check("t1_empty_req_o", bus.data_req_o, 4'b1000);
    check("t1_empty_gnt_o", bus.data_gnt_o, 0);
    drive(1'b0, rd_t3, 4'h0);
    step();

    // Back-to-back reads to slave 1 until full
    drive(1'b1, rd_t1, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t2_gnt_%0d", i), bus.data_gnt_o, 1);
      step();
    end
    #1;
    check("t2_full_req_o", bus.data_req_o, 4'h0);
    check("t2_full_gnt_o", bus.data_gnt_o, 0);
    respond(4'b0010, 1, 32'hD000_0000);
    #1;
    check("t2_full_pop_gnt", bus.data_gnt_o, 0);
    check("t2_pop_0", bus.data_r_rdata_o, 32'hD000_0000);
    step();
    drive(1'b0, rd_t1, 4'b0010);
    for (int i = 1; i < 4; i++) begin
      respond(4'b0010, 1, 32'hD000_0000 + 32'(i));
      #1;
      check($sformatf("t2_rvalid_%0d", i), bus.data_r_valid_o, 1);
      check($sformatf("t2_pop_%0d", i), bus.data_r_rdata_o, 32'hD000_0000 + 64'(i));
      step();
    end
    respond(4'b0000, 1, 32'h0);
    drive(1'b1, rd_t0, 4'h0);
    #1;
    check("t2_drained_req_o", bus.data_req_o, 4'b0001);
    check("t2_err_o", err, 0);
    drive(1'b0, rd_t0, 4'h0);
    step();

    // Simultaneous push/pop at cnt=2 on slave 1
    drive(1'b1, rd_t1, 4'b0010);
    step();
    step();
    respond(4'b0010, 1, 32'hBEEF_0001);
    #1;
    check("t4_gnt_o", bus.data_gnt_o, 1);
    check("t4_rvalid_o", bus.data_r_valid_o, 1);
    step();
    respond(4'b0000, 1, 32'h0);
    // cnt must still be 2: exactly two more pushes fit
    #1;
    check("t4_push3_gnt", bus.data_gnt_o, 1);
    step();
    #1;
    check("t4_push4_gnt", bus.data_gnt_o, 1);
    step();
    #1;
    check("t4_full_gnt", bus.data_gnt_o, 0);
    drive(1'b0, rd_t1, 4'h0);
    for (int i = 0; i < 4; i++) begin
      respond(4'b0010, 1, 32'hBEEF_0010 + 32'(i));
      #1;
      check($sformatf("t4_drain_%0d", i), bus.data_r_rdata_o, 32'hBEEF_0010 + 64'(i));
      step();
    end
    respond(4'b0000, 1, 32'h0);

    // Target switch stall: slave 0 in flight, then slave 3 requested
    drive(1'b1, rd_t0, 4'b0001);
    step();
    drive(1'b1, wr_t3, 4'b1001);
    #1;
    check("t3_stall_req_o", bus.data_req_o, 4'h0);
    check("t3_stall_gnt_o", bus.data_gnt_o, 0);
    step();
    respond(4'b0001, 0, 32'hAAAA_5555);
    #1;
    check("t3_pop_req_o", bus.data_req_o, 4'h0);
    check("t3_pop_rdata", bus.data_r_rdata_o, 32'hAAAA_5555);
    step();
    respond(4'b0000, 0, 32'h0);
    #1;
    check("t3_switch_req_o", bus.data_req_o, 4'b1000);
    check("t3_switch_gnt_o", bus.data_gnt_o, 1);
    check("t3_wen_o", bus.data_wen_o, 0);
    check("t3_wdata_o", bus.data_wdata_o, 32'h1234_5678);
    check("t3_be_o", bus.data_be_o, 4'h6);
    step();
    drive(1'b0, rd_t0, 4'h0);
    respond(4'b1000, 3, 32'h0000_0033);
    #1;
    check("t3_rdata_s3", bus.data_r_rdata_o, 32'h33);
    step();
    respond(4'b0000, 3, 32'h0);
    #1;
    check("t3_err_o", err, 0);

    // Spurious response while idle
    respond(4'b0010, 1, 32'h0BAD_0BAD);
    #1;
    check("t5_rvalid_o", bus.data_r_valid_o, 0);
    check("t5_err_pre", err, 0);
    step();
    respond(4'b0000, 1, 32'h0);
    #1;
    check("t5_err_set", err, 1);
    step();
    check("t5_err_sticky", err, 1);
    rst = 1'b1;
    #1;
    check("t5_err_rst", err, 0);
    #1 rst = 1'b0;
    step();

    // Reset mid-flight with three reads outstanding on slave 2
    drive(1'b1, rd_t2, 4'b0100);
    step();
    step();
    step();
    drive(1'b0, rd_t2, 4'h0);
    #2 rst = 1'b1;
    drive(1'b1, rd_t3, 4'b1000);
    #1;
    check("t6_open_req_o", bus.data_req_o, 4'b1000);
    check("t6_open_gnt_o", bus.data_gnt_o, 1);
    drive(1'b0, rd_t3, 4'h0);
    #1 rst = 1'b0;
    step();
    respond(4'b0100, 2, 32'hDEAD_BEEF);
    #1;
    check("t6_late_rvalid", bus.data_r_valid_o, 0);
    check("t6_late_rdata", bus.data_r_rdata_o, 0);
    step();
    respond(4'b0000, 2, 32'h0);
    #1;
    check("t6_late_err", err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
